// File: rtl/ehgu_fifo_wr_arbiter.sv
// ehgu_fifo_wr_arbiter: round-robin write-port arbiter and occupancy tracker for a single-clock FIFO.
// Revision 1.0
`default_nettype none

module ehgu_fifo_wr_arbiter #(
  parameter  int NREQ   = 4,
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 128,
  localparam int CWIDTH = $clog2(DEPTH + 1),
  localparam int IWIDTH = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    fifo_din_valid,
  output logic [WIDTH-1:0]        fifo_din,
  output logic [IWIDTH-1:0]       fifo_grant_id,
  input  logic                    fifo_pop,
  output logic [CWIDTH-1:0]       occupancy,
  output logic                    full,
  output logic                    empty,
  output logic                    drained,
  output logic                    underflow_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              run;
  logic [IWIDTH-1:0] rr_ptr;
  logic [NREQ-1:0]   rot;
  logic              found;
  logic [IWIDTH:0]   off, sum;
  logic [IWIDTH-1:0] winner;
  logic [WIDTH-1:0]  sel_data;
  logic              accept, pop_eff;
  logic [CWIDTH-1:0] occ_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN:   if (!en) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (en)                   state_nxt = S_RUN;
        else if (occupancy == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    run     = (state == S_RUN);
    drained = (state == S_IDLE) && (occupancy == '0);
  end

  // Rotate valids so bit 0 is rr_ptr, pick the lowest set bit, rotate back.
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> rr_ptr);
    found = 1'b0;
    off   = '0;
    for (int p = NREQ - 1; p >= 0; p--) begin
      if (rot[p]) begin
        found = 1'b1;
        off   = (IWIDTH + 1)'(p);
      end
    end
    sum = {1'b0, rr_ptr} + off;
    if (sum >= (IWIDTH + 1)'(NREQ)) sum = sum - (IWIDTH + 1)'(NREQ);
    winner = sum[IWIDTH-1:0];
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IWIDTH'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Space is judged on registered occupancy only; a same-cycle pop is not bypassed.
  assign req_ready = (run && found && (occupancy < CWIDTH'(DEPTH))) ?
                     (NREQ'(1) << winner) : '0;
  assign accept    = |(req_ready & req_valid);
  assign pop_eff   = fifo_pop && (occupancy != '0);
  assign full      = (occupancy == CWIDTH'(DEPTH));
  assign empty     = (occupancy == '0);

  always_comb begin
    occ_nxt = occupancy;
    case ({accept, pop_eff})
      2'b10:   occ_nxt = occupancy + CWIDTH'(1);
      2'b01:   occ_nxt = occupancy - CWIDTH'(1);
      default: occ_nxt = occupancy;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr         <= '0;
      occupancy      <= '0;
      fifo_din_valid <= 1'b0;
      fifo_din       <= '0;
      fifo_grant_id  <= '0;
      underflow_err  <= 1'b0;
    end else begin
      occupancy      <= occ_nxt;
      fifo_din_valid <= accept;
      if (accept) begin
        fifo_din      <= sel_data;
        fifo_grant_id <= winner;
        rr_ptr        <= (winner == IWIDTH'(NREQ - 1)) ? '0 : winner + IWIDTH'(1);
      end
      if (fifo_pop && (occupancy == '0)) underflow_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ehgu_fifo_wr_arbiter.sv
// Directed self-checking bench for ehgu_fifo_wr_arbiter (DEPTH=128 and DEPTH=5 instances).
`default_nettype none

module tb_ehgu_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst, en, pop, b_en, b_pop;
  logic [3:0]  valid, b_valid;
  logic [31:0] data;

  logic [3:0]  a_ready, b_ready;
  logic        a_dv, a_full, a_empty, a_drained, a_uerr;
  logic        b_dv, b_full, b_empty, b_drained, b_uerr;
  logic [7:0]  a_din, b_din;
  logic [1:0]  a_gid, b_gid;
  logic [7:0]  a_occ;
  logic [2:0]  b_occ;

  int checks   = 0;
  int failures = 0;
  logic [3:0] oh;

  always #5 clk = ~clk;

  ehgu_fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(128)) dut_a (
    .clk(clk), .rst(rst), .en(en), .req_valid(valid), .req_data(data),
    .req_ready(a_ready), .fifo_din_valid(a_dv), .fifo_din(a_din),
    .fifo_grant_id(a_gid), .fifo_pop(pop), .occupancy(a_occ), .full(a_full),
    .empty(a_empty), .drained(a_drained), .underflow_err(a_uerr)
  );

  ehgu_fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .req_valid(b_valid), .req_data(data),
    .req_ready(b_ready), .fifo_din_valid(b_dv), .fifo_din(b_din),
    .fifo_grant_id(b_gid), .fifo_pop(b_pop), .occupancy(b_occ), .full(b_full),
    .empty(b_empty), .drained(b_drained), .underflow_err(b_uerr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pop = 1'b0; valid = 4'hF;
    b_en = 1'b0; b_pop = 1'b0; b_valid = 4'h0;
    data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ", 32'(a_occ), 0);
    check("rst_full", 32'(a_full), 0);
    check("rst_empty", 32'(a_empty), 1);
    check("rst_drained", 32'(a_drained), 1);
    check("rst_ready", 32'(a_ready), 0);
    check("rst_dv", 32'(a_dv), 0);
    check("rst_din", 32'(a_din), 0);
    check("rst_gid", 32'(a_gid), 0);
    check("rst_uerr", 32'(a_uerr), 0);

    // Fill to DEPTH with all requesters valid: grants rotate 0,1,2,3
    rst = 1'b0; en = 1'b1;
    step();
    for (int k = 0; k < 128; k++) begin
      oh = 4'b0001 << (k % 4);
      check("fill_ready", 32'(a_ready), 32'(oh));
      check("fill_occ", 32'(a_occ), k);
      step();
      check("fill_dv", 32'(a_dv), 1);
      check("fill_gid", 32'(a_gid), k % 4);
      check("fill_din", 32'(a_din), 32'h A0 + (k % 4));
    end
    check("full_occ", 32'(a_occ), 128);
    check("full_flag", 32'(a_full), 1);
    check("full_ready", 32'(a_ready), 0);
    step();
    check("full_dv_low", 32'(a_dv), 0);
    check("full_gid_hold", 32'(a_gid), 3);
    check("full_occ_hold", 32'(a_occ), 128);

    // Single pop at full frees exactly one slot
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("pop_occ", 32'(a_occ), 127);
    check("pop_full", 32'(a_full), 0);
    check("pop_ready", 32'(a_ready), 32'h1);
    step();
    check("refill_occ", 32'(a_occ), 128);
    check("refill_gid", 32'(a_gid), 0);
    check("refill_ready", 32'(a_ready), 0);

    // Sparse valids {2,0} from rr_ptr=1
    valid = 4'b0000; pop = 1'b1;
    repeat (3) step();
    pop = 1'b0; valid = 4'b0101;
    #1;
    check("sp_occ", 32'(a_occ), 125);
    check("sp_ready0", 32'(a_ready), 32'b0100);
    step();
    check("sp_gid0", 32'(a_gid), 2);
    check("sp_din0", 32'(a_din), 32'hA2);
    check("sp_ready1", 32'(a_ready), 32'b0001);
    step();
    check("sp_gid1", 32'(a_gid), 0);
    check("sp_ready2", 32'(a_ready), 32'b0100);
    step();
    check("sp_gid2", 32'(a_gid), 2);
    check("sp_occ_full", 32'(a_occ), 128);
    check("sp_ready3", 32'(a_ready), 0);

    // Pop down to 3, then drain
    valid = 4'b0000; pop = 1'b1;
    repeat (125) step();
    pop = 1'b0;
    check("pre_drain_occ", 32'(a_occ), 3);
    en = 1'b0;
    step();
    valid = 4'hF;
    #1;
    check("drain_ready", 32'(a_ready), 0);
    check("drain_drained", 32'(a_drained), 0);
    pop = 1'b1;
    for (int k = 2; k >= 0; k--) begin
      step();
      check("drain_occ", 32'(a_occ), k);
      check("drain_dv", 32'(a_dv), 0);
    end
    pop = 1'b0;
    check("drain_empty", 32'(a_empty), 1);
    check("drain_not_idle", 32'(a_drained), 0);
    step();
    check("idle_drained", 32'(a_drained), 1);
    check("idle_ready", 32'(a_ready), 0);
    en = 1'b1;
    step();
    check("resume_ready", 32'(a_ready), 32'b1000);
    step();
    valid = 4'b0000;
    check("resume_gid", 32'(a_gid), 3);
    check("resume_occ", 32'(a_occ), 1);

    // Underflow is sticky
    pop = 1'b1;
    step();
    check("uf_occ", 32'(a_occ), 0);
    check("uf_before", 32'(a_uerr), 0);
    step();
    check("uf_set", 32'(a_uerr), 1);
    check("uf_occ0", 32'(a_occ), 0);
    pop = 1'b0;
    step();
    check("uf_sticky", 32'(a_uerr), 1);

    // Asynchronous reset mid-burst
    valid = 4'hF;
    step();
    step();
    check("burst_occ", 32'(a_occ), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_occ", 32'(a_occ), 0);
    check("arst_dv", 32'(a_dv), 0);
    check("arst_din", 32'(a_din), 0);
    check("arst_gid", 32'(a_gid), 0);
    check("arst_uerr", 32'(a_uerr), 0);
    check("arst_ready", 32'(a_ready), 0);
    check("arst_drained", 32'(a_drained), 1);
    step();
    rst = 1'b0; en = 1'b0; valid = 4'h0;

    // DEPTH=5 instance: saturates at 5, accept+pop holds
    b_en = 1'b1; b_valid = 4'hF;
    step();
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      check("b_ready", 32'(b_ready), 32'(oh));
      check("b_occ", 32'(b_occ), k);
      step();
    end
    check("b_full_occ", 32'(b_occ), 5);
    check("b_full", 32'(b_full), 1);
    check("b_full_ready", 32'(b_ready), 0);
    b_valid = 4'h0; b_pop = 1'b1;
    step();
    check("b_pop_occ4", 32'(b_occ), 4);
    step();
    check("b_pop_occ3", 32'(b_occ), 3);
    b_valid = 4'hF;
    #1;
    check("b_ap_ready", 32'(b_ready), 32'b0010);
    step();
    check("b_ap_occ", 32'(b_occ), 3);
    check("b_ap_gid", 32'(b_gid), 1);
    check("b_ap_dv", 32'(b_dv), 1);
    step();
    check("b_ap_occ2", 32'(b_occ), 3);
    check("b_ap_gid2", 32'(b_gid), 2);
    b_valid = 4'h0;
    repeat (3) step();
    b_pop = 1'b0;
    check("b_empty_occ", 32'(b_occ), 0);
    check("b_empty", 32'(b_empty), 1);
    check("b_uerr", 32'(b_uerr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ehgu_fifo_wr_arbiter.md
Name: ehgu_fifo_wr_arbiter

Overview:
Round-robin write-port arbiter and occupancy controller for the single-clock (SYNC_TYPE=1) configuration of the team FIFO logic/memory pair. It shares one FIFO write port between NREQ requesters using a valid/ready handshake. It drives the FIFO's din_valid and write data, and tracks occupancy from accepts and read-side pops. The FIFO logic has no full flag, so this block is the only overflow protection. It also sequences enable and drain so the FIFO can be quiesced before reconfiguration.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, data width per requester
DEPTH, 128, FIFO depth in entries (need not be a power of two)
CWIDTH, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)
IWIDTH, $clog2(NREQ) (min 1), grant index width (derived)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous reset, active-high
en  in  1  1 = arbitrate; 0 = stop accepting and drain
req_valid  in  NREQ  per-requester data valid
req_data  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  NREQ  per-requester accept; at most one bit high
fifo_din_valid  out  1  to FIFO logic din_valid (write strobe)
fifo_din  out  WIDTH  write data to FIFO memory
fifo_grant_id  out  IWIDTH  index of requester whose data is on fifo_din
fifo_pop  in  1  read-side entry consumed (FIFO dout_valid)
occupancy  out  CWIDTH  entries reserved or stored
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
drained  out  1  state IDLE and occupancy == 0
underflow_err  out  1  sticky: pop seen while occupancy == 0

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, occupancy=0, fifo_din_valid=0, fifo_din=0, fifo_grant_id=0, underflow_err=0. Outputs during reset: full=0, empty=1, drained=1, req_ready=0.
- States:
  - IDLE: en=1 -> RUN.
  - RUN: en=0 -> DRAIN.
  - DRAIN: en=1 -> RUN. en=0 and occupancy==0 -> IDLE.
- req_ready is combinational and nonzero only in RUN with occupancy < DEPTH. A pop in the same cycle does not create space; there is no bypass.
- Winner: the first i with req_valid[i]=1, searching cyclically from rr_ptr. req_ready[winner]=1 regardless of later valid changes. req_ready must not depend on req_ready of other requesters.
- Accept = req_valid[i] & req_ready[i]. On accept:
  - rr_ptr <= (i+1) mod NREQ.
  - Next cycle: fifo_din_valid=1, fifo_din=req_data[i] as sampled at accept, fifo_grant_id=i.
  - Write latency is exactly 1 cycle.
- No accept: fifo_din_valid <= 0. fifo_din and fifo_grant_id hold their last values.
- Occupancy update, each cycle:
  - +1 on accept.
  - -1 on fifo_pop when occupancy>0.
  - Accept and pop together: unchanged.
  - Pop at occupancy==0: no change; underflow_err <= 1 (cleared only by rst).
- Occupancy never exceeds DEPTH, and never wraps at non-power-of-two DEPTH.
- Occupancy counts on accept, so an entry still in the output register is counted. This keeps the FIFO logic's waddr from overtaking raddr.
- en falling with an accept in the same cycle: that accept completes. The next cycle is DRAIN with req_ready=0.
- Drain wait: DRAIN waits for pops only and issues no writes.
- Mid-operation rst: all state is lost immediately. The FIFO logic must be reset in the same domain.
- full, empty and drained are combinational from registered state.

Test Plan:
- Reset then en=1, all four req_valid=1 held, no pops -> grants 0,1,2,3,0… one per cycle. fifo_din_valid=1 from the cycle after the first accept. fifo_grant_id lags req_ready by 1. occupancy reaches 128, then full=1 and req_ready=0.
- Full (occupancy=128), fifo_pop pulsed for one cycle -> occupancy=127 the next cycle. The cycle after that, exactly one accept; occupancy back to 128.
- Only req_valid[2] and req_valid[0] set, rr_ptr=1 -> grant 2, then 0, then 2; requesters 1 and 3 are never readied.
- DEPTH=5 (non-power-of-two) with continuous accepts and pops -> occupancy stays within 0..5 and never wraps. Simultaneous accept+pop at occupancy 5 is impossible because ready is 0. At occupancy 3, accept+pop leaves 3.
- Occupancy=3, en=0 -> next cycle DRAIN, req_ready=0. Three pops -> occupancy=0, then IDLE, drained=1. en=1 -> RUN, accepts resume from the saved rr_ptr.
- fifo_pop at occupancy 0 -> underflow_err=1 and stays set. Assert rst mid-burst -> all outputs immediately return to their reset values.
